// File: rtl/mix_matrix_seq.sv
// Sequential stereo mix matrix: one MAC per cycle per side, then a master gain stage per output.
// Gains slew toward their targets once per frame; outputs update atomically when a frame completes.
module mix_matrix_seq #(
  parameter int BIT       = 24,
  parameter int VOL_BIT   = 8,
  parameter int AD_NUM    = 2,
  parameter int DA_NUM    = 2,
  parameter int RAMP_STEP = 0,
  parameter int ADDR_W    = $clog2(AD_NUM*DA_NUM+DA_NUM)
)(
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     FS,
  input  logic [AD_NUM*BIT-1:0]    AD_L,
  input  logic [AD_NUM*BIT-1:0]    AD_R,
  input  logic                     VOL_WE,
  input  logic [ADDR_W-1:0]        VOL_ADDR,
  input  logic [VOL_BIT-1:0]       VOL_DATA,
  output logic [DA_NUM*BIT-1:0]    DA_L,
  output logic [DA_NUM*BIT-1:0]    DA_R,
  output logic                     OUT_VALID,
  output logic                     BUSY,
  output logic                     OVERRUN
);
  localparam int NG = AD_NUM*DA_NUM + DA_NUM;
  localparam int AW = BIT + VOL_BIT + $clog2(AD_NUM) + 1;
  localparam int PW = BIT + VOL_BIT + 1;
  localparam int IW = (AD_NUM > 1) ? $clog2(AD_NUM) : 1;
  localparam int JW = (DA_NUM > 1) ? $clog2(DA_NUM) : 1;
  localparam logic [IW-1:0]      I_LAST = IW'(AD_NUM-1);
  localparam logic [JW-1:0]      J_LAST = JW'(DA_NUM-1);
  localparam logic [VOL_BIT-1:0] STEP   = VOL_BIT'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE, ACC, MST, DONE} state_t;
  state_t state, state_nxt;

  logic [AD_NUM-1:0][BIT-1:0]  snap_l, snap_r;
  logic [NG-1:0][VOL_BIT-1:0]  tgt, app, app_nxt;
  logic [DA_NUM-1:0][BIT-1:0]  stage_l, stage_r, stage_l_nxt, stage_r_nxt;
  logic signed [AW-1:0]        acc_l, acc_r;
  logic signed [PW-1:0]        prod_l, prod_r;
  logic [BIT-1:0]              mst_l, mst_r;
  logic [IW-1:0]               i;
  logic [JW-1:0]               j;
  logic [ADDR_W-1:0]           xidx, midx;

  function automatic logic [VOL_BIT-1:0] ramp(input logic [VOL_BIT-1:0] a, input logic [VOL_BIT-1:0] t);
    if (STEP == '0) return t;
    if (a < t) return (t - a > STEP) ? a + STEP : t;
    return (a - t > STEP) ? a - STEP : t;
  endfunction

  // Saturate when the bits above the BIT-wide result are not a pure sign extension.
  function automatic logic [BIT-1:0] sat(input logic signed [AW-1:0] v);
    if (v[AW-1:BIT-1] == {(AW-BIT+1){v[AW-1]}}) return v[BIT-1:0];
    return v[AW-1] ? {1'b1, {(BIT-1){1'b0}}} : {1'b0, {(BIT-1){1'b1}}};
  endfunction

  function automatic logic [BIT-1:0] master(input logic signed [AW-1:0] a, input logic [VOL_BIT-1:0] g);
    logic signed [BIT-1:0] s;
    logic signed [PW-1:0]  m;
    s = sat(a >>> (VOL_BIT-1));
    m = s * $signed({1'b0, g});
    return sat(AW'(m >>> (VOL_BIT-1)));
  endfunction

  assign xidx   = ADDR_W'(DA_NUM*int'(i) + int'(j));
  assign midx   = ADDR_W'(AD_NUM*DA_NUM + int'(j));
  assign prod_l = $signed(snap_l[i]) * $signed({1'b0, app[xidx]});
  assign prod_r = $signed(snap_r[i]) * $signed({1'b0, app[xidx]});
  assign mst_l  = master(acc_l, app[midx]);
  assign mst_r  = master(acc_r, app[midx]);

  always_comb begin
    stage_l_nxt    = stage_l;
    stage_r_nxt    = stage_r;
    stage_l_nxt[j] = mst_l;
    stage_r_nxt[j] = mst_r;
    for (int k = 0; k < NG; k++) app_nxt[k] = ramp(app[k], tgt[k]);
  end

  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (FS) state_nxt = ACC;
      ACC:     if (i == I_LAST) state_nxt = MST;
      MST:     state_nxt = (j == J_LAST) ? DONE : ACC;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY      = (state != IDLE);
    OUT_VALID = (state == DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      snap_l <= '0; snap_r <= '0; tgt <= '0; app <= '0;
      acc_l <= '0; acc_r <= '0; stage_l <= '0; stage_r <= '0;
      i <= '0; j <= '0; DA_L <= '0; DA_R <= '0; OVERRUN <= 1'b0;
    end else begin
      if (VOL_WE && int'(VOL_ADDR) < NG) tgt[VOL_ADDR] <= VOL_DATA;
      if (FS && state != IDLE) OVERRUN <= 1'b1;
      case (state)
        IDLE: if (FS) begin
          snap_l <= AD_L; snap_r <= AD_R; app <= app_nxt;
          acc_l <= '0; acc_r <= '0; i <= '0; j <= '0;
        end
        ACC: begin
          acc_l <= acc_l + AW'(prod_l);
          acc_r <= acc_r + AW'(prod_r);
          i     <= i + 1'b1;
        end
        MST: begin
          stage_l <= stage_l_nxt;
          stage_r <= stage_r_nxt;
          // The last output goes straight to DA together with the rest so DONE presents a whole frame.
          if (j == J_LAST) begin
            DA_L <= stage_l_nxt;
            DA_R <= stage_r_nxt;
          end else begin
            j <= j + 1'b1; i <= '0; acc_l <= '0; acc_r <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mix_matrix_seq.sv
// Scoreboard bench for mix_matrix_seq: two instances (immediate gains and RAMP_STEP=16) on shared stimulus.
module tb_mix_matrix_seq;
  localparam int NG = 6;
  localparam int AW = 3;

  logic clk = 0, rst = 1, fs = 0, vol_we = 0;
  logic [AW-1:0] vol_addr = '0;
  logic [7:0]    vol_data = '0;
  logic [47:0]   ad_l = '0, ad_r = '0;
  logic [47:0]   da_l0, da_r0, da_l1, da_r1;
  logic ov0, ov1, busy0, busy1, ovr0, ovr1;
  int cyc = 0, n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mix_matrix_seq #(.BIT(24), .VOL_BIT(8), .AD_NUM(2), .DA_NUM(2), .RAMP_STEP(0)) dut0 (
    .CLK(clk), .RST(rst), .FS(fs), .AD_L(ad_l), .AD_R(ad_r), .VOL_WE(vol_we),
    .VOL_ADDR(vol_addr), .VOL_DATA(vol_data), .DA_L(da_l0), .DA_R(da_r0),
    .OUT_VALID(ov0), .BUSY(busy0), .OVERRUN(ovr0));

  mix_matrix_seq #(.BIT(24), .VOL_BIT(8), .AD_NUM(2), .DA_NUM(2), .RAMP_STEP(16)) dut1 (
    .CLK(clk), .RST(rst), .FS(fs), .AD_L(ad_l), .AD_R(ad_r), .VOL_WE(vol_we),
    .VOL_ADDR(vol_addr), .VOL_DATA(vol_data), .DA_L(da_l1), .DA_R(da_r1),
    .OUT_VALID(ov1), .BUSY(busy1), .OVERRUN(ovr1));

  typedef struct { int cyc; logic [47:0] l0, r0, l1, r1; } exp_t;
  exp_t q[$];
  int tgt[NG], app0[NG], app1[NG];
  int t_last = -100, ovr_at = 1 << 30;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic longint sat24(input longint v);
    if (v > 64'sd8388607)  return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  function automatic int ramp16(input int a, input int t);
    if (a < t) return (t - a > 16) ? a + 16 : t;
    return (a - t > 16) ? a - 16 : t;
  endfunction

  // Reference mix: out_j = sat(sat(sum_i x_i*g[2i+j] >> 7) * g[4+j] >> 7)
  function automatic logic [47:0] mix(input logic [47:0] x, input int g[NG]);
    logic [47:0] o;
    longint acc, s;
    o = '0;
    for (int jj = 0; jj < 2; jj++) begin
      acc = 0;
      for (int ii = 0; ii < 2; ii++) acc += longint'($signed(x[ii*24 +: 24])) * g[2*ii+jj];
      s = sat24(acc >>> 7);
      s = sat24((s * g[4+jj]) >>> 7);
      o[jj*24 +: 24] = s[23:0];
    end
    return o;
  endfunction

  // One clock of stimulus; model bookkeeping refers to the edge this call is about to hit.
  task automatic step(input bit f, input bit we, input int addr, input int data);
    int t0;
    exp_t e;
    t0 = cyc + 1;
    if (f) begin
      if (t0 >= t_last + 8) begin
        for (int k = 0; k < NG; k++) begin
          app0[k] = tgt[k];
          app1[k] = ramp16(app1[k], tgt[k]);
        end
        e.cyc = t0 + 6;
        e.l0 = mix(ad_l, app0); e.r0 = mix(ad_r, app0);
        e.l1 = mix(ad_l, app1); e.r1 = mix(ad_r, app1);
        q.push_back(e);
        t_last = t0;
      end else if (ovr_at > t0) ovr_at = t0;
    end
    if (we && addr < NG) tgt[addr] = data;
    fs = f; vol_we = we; vol_addr = AW'(addr); vol_data = 8'(data);
    @(posedge clk); #1;
    fs = 0; vol_we = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    step(0, 1, a, d);
  endtask

  task automatic frame(input logic [47:0] l, input logic [47:0] r);
    ad_l = l; ad_r = r;
    step(1, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 0;
    q.delete();
    for (int k = 0; k < NG; k++) begin tgt[k] = 0; app0[k] = 0; app1[k] = 0; end
    t_last = -100; ovr_at = 1 << 30;
    #1;
    chk("rst_da_l0", da_l0, 0); chk("rst_da_r0", da_r0, 0);
    chk("rst_da_l1", da_l1, 0); chk("rst_da_r1", da_r1, 0);
    chk("rst_busy", {busy0, busy1}, 0); chk("rst_valid", {ov0, ov1}, 0);
    chk("rst_overrun", {ovr0, ovr1}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
  endtask

  // Monitor: every cycle, valid/busy/overrun against the model; data when a frame is due.
  always @(negedge clk) begin
    bit fire, bexp;
    fire = (q.size() > 0) && (q[0].cyc == cyc);
    bexp = (cyc >= t_last) && (cyc <= t_last + 6);
    chk("out_valid0", ov0, fire);  chk("out_valid1", ov1, fire);
    chk("busy0", busy0, bexp);     chk("busy1", busy1, bexp);
    chk("overrun0", ovr0, cyc >= ovr_at); chk("overrun1", ovr1, cyc >= ovr_at);
    if (fire) begin
      chk("da_l0", da_l0, q[0].l0); chk("da_r0", da_r0, q[0].r0);
      chk("da_l1", da_l1, q[0].l1); chk("da_r1", da_r1, q[0].r1);
      void'(q.pop_front());
    end
  end

  initial begin
    #2;
    do_reset();

    // unity path
    wr(0, 128); wr(4, 128);
    frame({24'h0, 24'h100000}, 48'h0); idle(8);
    chk("unity_l", da_l0, 48'h000000_100000); chk("unity_r", da_r0, 48'h0);

    // mix with saturation on both sides
    wr(0, 255); wr(2, 255); wr(4, 255);
    frame({24'h7FFFFF, 24'h7FFFFF}, {24'h800000, 24'h800000}); idle(8);
    chk("sat_l", da_l0, 48'h000000_7FFFFF); chk("sat_r", da_r0, 48'h000000_800000);

    // out-of-range gain writes must be ignored
    wr(6, 255); wr(7, 255);
    frame({24'h7FFFFF, 24'h7FFFFF}, {24'h800000, 24'h800000}); idle(8);
    chk("badaddr_l", da_l0, 48'h000000_7FFFFF); chk("badaddr_r", da_r0, 48'h000000_800000);

    // overrun: second FS 3 cycles in, then FS right after OUT_VALID
    frame({24'h000100, 24'h123456}, {24'hFEDCBA, 24'h000042}); idle(2);
    frame(48'h0, 48'h0); idle(4);
    frame({24'h000200, 24'h001000}, {24'h000300, 24'h700000}); idle(8);
    chk("overrun_sticky", {ovr0, ovr1}, 2'b11);

    // randomized frames with writes and stray strobes while busy
    for (int k = 0; k < NG; k++) wr(k, $urandom_range(0, 255));
    for (int n = 0; n < 20; n++) begin
      wr($urandom_range(0, 7), $urandom_range(0, 255));
      wr($urandom_range(0, 7), $urandom_range(0, 255));
      frame(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}));
      idle(3);
      step($urandom_range(0, 3) == 0, 1, $urandom_range(0, 7), $urandom_range(0, 255));
      idle($urandom_range(1, 4));
    end
    idle(8);

    // reset in the middle of a frame
    for (int k = 0; k < NG; k++) wr(k, 200);
    frame({24'h300000, 24'h100000}, {24'h0F0000, 24'hC00000}); idle(3);
    do_reset();
    frame({24'h300000, 24'h100000}, {24'h0F0000, 24'hC00000}); idle(8);
    chk("post_rst_muted", {da_l0, da_r0}, 96'h0);

    // ramp: up to unity over 8 frames, then crosspoint down to 0 over 8
    wr(0, 128); wr(4, 128);
    repeat (8) begin frame({24'h0, 24'h100000}, 48'h0); idle(7); end
    chk("ramp_up_f8", da_l1[23:0], 24'h100000);
    repeat (2) begin frame({24'h0, 24'h100000}, 48'h0); idle(7); end
    wr(0, 0);
    repeat (8) begin frame({24'h0, 24'h100000}, 48'h0); idle(7); end
    chk("ramp_down_f8", da_l1[23:0], 24'h0);

    idle(10);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
